sopc_led_pwm_pio: RTL and testbench

SOPC_LED_PWM_PIO -- requirements
Module: sopc_led_pwm_pio

---
 rtl/sopc_pio_pkg.sv | 27 ++
 rtl/sopc_pwm_gen.sv | 52 +++++
 rtl/sopc_led_pwm_pio.sv | 116 +++++++++++
 tb/tb_sopc_led_pwm_pio.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sopc_pio_pkg.sv
// Shared register map for the LED PWM PIO: word addresses and the register-index enum.
package sopc_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_SET      = 3'd1;
  localparam logic [2:0] ADDR_CLR      = 3'd2;
  localparam logic [2:0] ADDR_MODE     = 3'd3;
  localparam logic [2:0] ADDR_DUTY     = 3'd4;
  localparam logic [2:0] ADDR_PRESCALE = 3'd5;
  localparam logic [2:0] ADDR_PWMCNT   = 3'd6;
  localparam logic [2:0] ADDR_RSVD     = 3'd7;

  localparam int unsigned PRESCALE_BITS = 16;
  localparam int unsigned BUS_BITS      = 32;

  typedef enum logic [2:0] {
    RegData     = ADDR_DATA,
    RegSet      = ADDR_SET,
    RegClr      = ADDR_CLR,
    RegMode     = ADDR_MODE,
    RegDuty     = ADDR_DUTY,
    RegPrescale = ADDR_PRESCALE,
    RegPwmcnt   = ADDR_PWMCNT,
    RegRsvd     = ADDR_RSVD
  } reg_idx_e;

endpackage

// File: rtl/sopc_pwm_gen.sv
// Prescaled PWM counter with a duty shadow register that only changes at a period start.
module sopc_pwm_gen
  import sopc_pio_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_restart,
  input  logic [PRESCALE_BITS-1:0] i_prescale,
  input  logic [PWM_BITS-1:0]      i_duty,
  output logic                     o_pwm_on,
  output logic [PWM_BITS-1:0]      o_pwmcnt
);

  logic [PRESCALE_BITS-1:0] r_presc;
  logic [PWM_BITS-1:0]      r_cnt;
  logic [PWM_BITS-1:0]      r_shadow;
  logic                     w_tick;
  logic                     w_wrap;

  assign w_tick = (r_presc == '0);
  assign w_wrap = w_tick && (r_cnt == '1);

  // i_prescale / i_duty carry the post-write register values, so a coincident
  // DUTY write at the wrap lands straight in the shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc  <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
    end else if (i_restart) begin
      r_presc  <= i_prescale;
      r_cnt    <= '0;
      r_shadow <= i_duty;
    end else begin
      if (w_tick) begin
        r_presc <= i_prescale;
        r_cnt   <= r_cnt + 1'b1;
      end else begin
        r_presc <= r_presc - 1'b1;
      end
      if (w_wrap) begin
        r_shadow <= i_duty;
      end
    end
  end

  assign o_pwm_on = (r_cnt < r_shadow);
  assign o_pwmcnt = r_cnt;

endmodule

// File: rtl/sopc_led_pwm_pio.sv
// Memory-mapped LED PIO: DATA with atomic set/clear, per-channel PWM gating by MODE.
module sopc_led_pwm_pio
  import sopc_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 10,
  parameter int unsigned      PWM_BITS    = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic                read_n,
  input  logic [BUS_BITS-1:0] writedata,
  output logic [BUS_BITS-1:0] readdata,
  output logic [WIDTH-1:0]    out_port
);

  reg_idx_e                 w_idx;
  logic                     w_wr;
  logic                     w_rd;
  logic [WIDTH-1:0]         w_wdata;

  logic [WIDTH-1:0]         r_data;
  logic [WIDTH-1:0]         w_data_d;
  logic [WIDTH-1:0]         r_mode;
  logic [WIDTH-1:0]         w_mode_d;
  logic [PWM_BITS-1:0]      r_duty;
  logic [PWM_BITS-1:0]      w_duty_d;
  logic [PRESCALE_BITS-1:0] r_prescale;
  logic [PRESCALE_BITS-1:0] w_prescale_d;
  logic                     w_prescale_wr;

  logic [BUS_BITS-1:0]      r_rdata;
  logic [BUS_BITS-1:0]      w_rdata;
  logic [WIDTH-1:0]         r_out;
  logic                     w_pwm_on;
  logic [PWM_BITS-1:0]      w_pwmcnt;

  assign w_idx   = reg_idx_e'(address);
  assign w_wr    = chipselect && !write_n;
  assign w_rd    = chipselect && !read_n;
  assign w_wdata = writedata[WIDTH-1:0];

  always_comb begin
    w_data_d      = r_data;
    w_mode_d      = r_mode;
    w_duty_d      = r_duty;
    w_prescale_d  = r_prescale;
    w_prescale_wr = 1'b0;
    if (w_wr) begin
      case (w_idx)
        RegData:  w_data_d = w_wdata;
        RegSet:   w_data_d = r_data | w_wdata;
        RegClr:   w_data_d = r_data & ~w_wdata;
        RegMode:  w_mode_d = w_wdata;
        RegDuty:  w_duty_d = writedata[PWM_BITS-1:0];
        RegPrescale: begin
          w_prescale_d  = writedata[PRESCALE_BITS-1:0];
          w_prescale_wr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      RegData:     w_rdata[WIDTH-1:0]         = r_data;
      RegMode:     w_rdata[WIDTH-1:0]         = r_mode;
      RegDuty:     w_rdata[PWM_BITS-1:0]      = r_duty;
      RegPrescale: w_rdata[PRESCALE_BITS-1:0] = r_prescale;
      RegPwmcnt:   w_rdata[PWM_BITS-1:0]      = w_pwmcnt;
      default: ;
    endcase
  end

  sopc_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm_gen (
    .clk        (clk),
    .reset      (reset),
    .i_restart  (w_prescale_wr),
    .i_prescale (w_prescale_d),
    .i_duty     (w_duty_d),
    .o_pwm_on   (w_pwm_on),
    .o_pwmcnt   (w_pwmcnt)
  );

  // out_port is built from next-state DATA/MODE so a write shows up one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data     <= RESET_VALUE;
      r_mode     <= '0;
      r_duty     <= '0;
      r_prescale <= '0;
      r_rdata    <= '0;
      r_out      <= RESET_VALUE;
    end else begin
      r_data     <= w_data_d;
      r_mode     <= w_mode_d;
      r_duty     <= w_duty_d;
      r_prescale <= w_prescale_d;
      if (w_rd) begin
        r_rdata <= w_rdata;
      end
      r_out <= w_data_d & (~w_mode_d | {WIDTH{w_pwm_on}});
    end
  end

  assign readdata = r_rdata;
  assign out_port = r_out;

endmodule

// File: tb/tb_sopc_led_pwm_pio.sv
// Scoreboard bench for sopc_led_pwm_pio: reads queue expectations, a monitor compares readdata.
module tb_sopc_led_pwm_pio;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned PWM_BITS = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        address;
  logic              chipselect;
  logic              write_n;
  logic              read_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [WIDTH-1:0]  out_port;

  int                n_cmp = 0;
  int                n_bad = 0;
  logic [31:0]       exp_q[$];
  string             name_q[$];
  logic              rd_valid = 1'b0;

  sopc_led_pwm_pio #(
    .WIDTH       (WIDTH),
    .PWM_BITS    (PWM_BITS),
    .RESET_VALUE (10'h2A5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // A read strobe sampled at an edge means readdata is valid from that edge on.
  always @(posedge clk) rd_valid <= chipselect && !read_n && !reset;

  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read: got 0x%08h, expected no read", readdata);
      end else begin
        check(name_q.pop_front(), readdata, exp_q.pop_front());
      end
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string nm);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    address    = a;
    chipselect = 1'b1;
    read_n     = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  task automatic count_high(input int n, output int hi, output int other);
    hi = 0;
    other = 0;
    repeat (n) begin
      @(negedge clk);
      if (out_port[0]) hi++;
      if (out_port[WIDTH-1:1] != '0) other++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int other;
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    writedata  = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_out_port", {22'h0, out_port}, 32'h0000_02A5);
    bus_read(3'd0, 32'h0000_02A5, "reset_data");
    bus_read(3'd3, 32'h0, "reset_mode");
    bus_read(3'd4, 32'h0, "reset_duty");
    bus_read(3'd5, 32'h0, "reset_prescale");

    bus_write(3'd0, 32'h0000_00F0);
    bus_write(3'd1, 32'h0000_0301);
    bus_write(3'd2, 32'h0000_0010);
    check("setclr_out_port", {22'h0, out_port}, 32'h0000_03E1);
    bus_read(3'd0, 32'h0000_03E1, "setclr_data");
    bus_read(3'd1, 32'h0, "read_set_zero");
    bus_read(3'd2, 32'h0, "read_clr_zero");

    bus_write(3'd0, 32'hFFFF_FFFF);
    bus_read(3'd0, 32'h0000_03FF, "data_truncated");
    bus_write(3'd7, 32'h0);
    bus_read(3'd0, 32'h0000_03FF, "rsvd_write_ignored");
    bus_read(3'd7, 32'h0, "read_rsvd_zero");

    // Write presented on a reset edge must be discarded.
    @(posedge clk);
    #1;
    address    = 3'd0;
    writedata  = 32'h0;
    chipselect = 1'b1;
    write_n    = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    reset      = 1'b0;
    check("reset_prio_out_port", {22'h0, out_port}, 32'h0000_02A5);
    bus_read(3'd0, 32'h0000_02A5, "reset_prio_data");

    bus_write(3'd3, 32'h1);
    bus_write(3'd0, 32'h1);
    bus_write(3'd4, 32'd64);
    bus_write(3'd5, 32'd0);
    @(negedge clk);
    count_high(256, hi, other);
    check("pwm64_period1_high", hi, 64);
    count_high(256, hi, other);
    check("pwm64_period2_high", hi, 64);
    check("pwm64_upper_bits_low", other, 0);

    // Resync: counter is 0 after the PRESCALE write edge; DUTY lands at count 101.
    bus_write(3'd5, 32'd0);
    repeat (99) @(posedge clk);
    bus_write(3'd4, 32'd192);
    count_high(155, hi, other);
    check("duty_old_holds_to_wrap", hi, 0);
    count_high(256, hi, other);
    check("duty_new_next_period", hi, 192);
    bus_read(3'd4, 32'd192, "duty_readback");

    bus_write(3'd5, 32'd3);
    for (int i = 0; i < 4; i++) begin
      bus_read(3'd6, i, $sformatf("pwmcnt_presc3_%0d", i));
      if (i < 3) repeat (2) @(posedge clk);
    end
    bus_write(3'd5, 32'd3);
    bus_read(3'd6, 32'h0, "pwmcnt_cleared_by_prescale");
    bus_read(3'd5, 32'd3, "prescale_readback");
    bus_read(3'd3, 32'h1, "mode_readback");

    repeat (4) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
